// File: rtl/fsm_link_pkg.sv
// Shared definitions for the frame serializer and the sequence-detector link:
// state encoding, default frame geometry and counter sizing.
package fsm_link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam int DEF_WIDTH = 3;
   localparam int DEF_GAP   = 1;

   // The shared down-counter holds at most WIDTH-1 or GAP_CYCLES-1; never narrower than 1 bit.
   function automatic int cnt_width(input int width, input int gap);
      int m;
      m = (width > gap + 1) ? width : gap + 1;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/frame_serializer.sv
// Serializes one parallel word per frame: a clear pulse, WIDTH bits MSB-first,
// then GAP_CYCLES idle cycles. Counts completed frames modulo 256.
module frame_serializer
   import fsm_link_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int GAP_CYCLES = DEF_GAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_clr_n,
   output logic [7:0]       frame_cnt,
   output state_t           dbg_state
);

   // Handshake: a word is taken at a rising edge where data_valid and data_ready are both 1;
   // data_ready depends only on registered state, and the producer must hold the word until taken.

   localparam int CW = cnt_width(WIDTH, GAP_CYCLES);
   localparam logic [CW-1:0] LOAD_BITS = CW'(WIDTH - 1);
   localparam logic [CW-1:0] LOAD_GAP  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic [7:0]       r_frame_cnt;
   logic             w_cnt_zero;

   assign w_cnt_zero = (r_cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (data_valid) w_next_state = ST_CLEAR;
         ST_CLEAR: w_next_state = ST_SHIFT;
         ST_SHIFT: if (w_cnt_zero) w_next_state = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
         ST_GAP:   if (w_cnt_zero) w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // One counter serves both the bit phase and the gap phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift     <= '0;
         r_cnt       <= '0;
         r_frame_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (data_valid) r_shift <= data_in;
            end
            ST_CLEAR: begin
               r_cnt <= LOAD_BITS;
            end
            ST_SHIFT: begin
               r_shift <= r_shift << 1;
               if (w_cnt_zero) begin
                  r_frame_cnt <= r_frame_cnt + 8'd1;
                  r_cnt       <= LOAD_GAP;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            ST_GAP: begin
               if (!w_cnt_zero) r_cnt <= r_cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      data_ready  = 1'b0;
      ser_out     = 1'b0;
      ser_valid   = 1'b0;
      frame_clr_n = 1'b1;
      case (r_state)
         ST_IDLE:  data_ready  = 1'b1;
         ST_CLEAR: frame_clr_n = 1'b0;
         ST_SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = r_shift[WIDTH-1];
         end
         default: ;
      endcase
   end

   assign frame_cnt = r_frame_cnt;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: default instance (3 bits, gap 1) and a WIDTH=1/GAP=0 instance,
// both compared cycle by cycle against a queue-based frame model.
module tb_frame_serializer;
   import fsm_link_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1;

   logic [2:0] din_a = '0;
   logic       val_a = 1'b0;
   logic       rdy_a, so_a, sv_a, clr_a;
   logic [7:0] cnt_a;
   state_t     st_a;

   logic       din_b = 1'b0;
   logic       val_b = 1'b0;
   logic       rdy_b, so_b, sv_b, clr_b;
   logic [7:0] cnt_b;
   state_t     st_b;

   int n_total = 0;
   int n_bad   = 0;
   logic run_chk = 1'b1;

   frame_serializer #(.WIDTH(3), .GAP_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst), .data_in(din_a), .data_valid(val_a), .data_ready(rdy_a),
      .ser_out(so_a), .ser_valid(sv_a), .frame_clr_n(clr_a), .frame_cnt(cnt_a), .dbg_state(st_a)
   );

   frame_serializer #(.WIDTH(1), .GAP_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .data_in(din_b), .data_valid(val_b), .data_ready(rdy_b),
      .ser_out(so_b), .ser_valid(sv_b), .frame_clr_n(clr_b), .frame_cnt(cnt_b), .dbg_state(st_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Per-cycle expectation: {last_bit, ready, clr_n, ser_valid, ser_out}.
   localparam logic [4:0] IDLE_T = 5'b01100;

   function automatic logic [4:0] frame_tuple(input int w, input logic [15:0] word, input int j);
      if (j == 0) return 5'b00000;
      if (j <= w) return {(j == w), 1'b0, 1'b1, 1'b1, word[w-j]};
      return 5'b00100;
   endfunction

   function automatic logic [1:0] exp_state(input logic [4:0] t);
      if (t[3])  return 2'd0;
      if (!t[2]) return 2'd1;
      if (t[1])  return 2'd2;
      return 2'd3;
   endfunction

   logic [4:0] exp_q_a[$];
   logic [4:0] cur_a = IDLE_T;
   logic [7:0] mcnt_a = '0;
   int         acc_a = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q_a.delete();
         cur_a  = IDLE_T;
         mcnt_a = '0;
      end else begin
         if (cur_a[4]) mcnt_a = mcnt_a + 8'd1;
         if (cur_a[3] && val_a) begin
            for (int j = 0; j <= 3 + 1; j++) exp_q_a.push_back(frame_tuple(3, {13'b0, din_a}, j));
            acc_a++;
         end
         cur_a = (exp_q_a.size() > 0) ? exp_q_a.pop_front() : IDLE_T;
      end
   end

   logic [4:0] exp_q_b[$];
   logic [4:0] cur_b = IDLE_T;
   logic [7:0] mcnt_b = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q_b.delete();
         cur_b  = IDLE_T;
         mcnt_b = '0;
      end else begin
         if (cur_b[4]) mcnt_b = mcnt_b + 8'd1;
         if (cur_b[3] && val_b) begin
            for (int j = 0; j <= 1 + 0; j++) exp_q_b.push_back(frame_tuple(1, {15'b0, din_b}, j));
         end
         cur_b = (exp_q_b.size() > 0) ? exp_q_b.pop_front() : IDLE_T;
      end
   end

   always @(negedge clk) begin
      if (run_chk) begin
         check("a_ready",     {31'b0, rdy_a}, {31'b0, cur_a[3]});
         check("a_clr_n",     {31'b0, clr_a}, {31'b0, cur_a[2]});
         check("a_ser_valid", {31'b0, sv_a},  {31'b0, cur_a[1]});
         check("a_ser_out",   {31'b0, so_a},  {31'b0, cur_a[0]});
         check("a_frame_cnt", {24'b0, cnt_a}, {24'b0, mcnt_a});
         check("a_state",     {30'b0, st_a},  {30'b0, exp_state(cur_a)});
         check("b_ready",     {31'b0, rdy_b}, {31'b0, cur_b[3]});
         check("b_clr_n",     {31'b0, clr_b}, {31'b0, cur_b[2]});
         check("b_ser_valid", {31'b0, sv_b},  {31'b0, cur_b[1]});
         check("b_ser_out",   {31'b0, so_b},  {31'b0, cur_b[0]});
         check("b_frame_cnt", {24'b0, cnt_b}, {24'b0, mcnt_b});
         check("b_state",     {30'b0, st_b},  {30'b0, exp_state(cur_b)});
      end
   end

   // Instance B sees a busy random producer for the whole run.
   always @(posedge clk) begin
      #1;
      val_b = ($urandom_range(0, 3) != 0);
      din_b = 1'($urandom);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a word and hold it until the model reports it taken.
   task automatic send_a(input logic [2:0] w);
      int start;
      start = acc_a;
      val_a = 1'b1;
      din_a = w;
      for (int i = 0; i < 50 && acc_a == start; i++) tick();
      if (acc_a == start) check("a_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle_a(input int n);
      val_a = 1'b0;
      din_a = 3'($urandom);
      repeat (n) tick();
   endtask

   initial begin
      val_a = 1'b1;
      din_a = 3'b101;
      #1 rst = 1'b0;
      repeat (4) tick();
      check("rst_ready", {31'b0, rdy_a}, 32'd1);
      check("rst_cnt",   {24'b0, cnt_a}, 32'd0);
      val_a = 1'b0;
      rst   = 1'b1;
      idle_a(2);

      send_a(3'b101);
      idle_a(8);
      check("single_cnt", {24'b0, cnt_a}, 32'd1);

      for (int w = 0; w < 8; w++) send_a(3'(w));
      idle_a(8);
      check("eight_cnt", {24'b0, cnt_a}, 32'd9);

      send_a(3'b110);
      send_a(3'b011);
      idle_a(8);
      check("bp_cnt", {24'b0, cnt_a}, 32'd11);

      send_a(3'b111);
      val_a = 1'b0;
      repeat (2) tick();
      #1 rst = 1'b0;
      #1;
      check("abort_ser_valid", {31'b0, sv_a},  32'd0);
      check("abort_clr_n",     {31'b0, clr_a}, 32'd1);
      check("abort_ready",     {31'b0, rdy_a}, 32'd1);
      check("abort_cnt",       {24'b0, cnt_a}, 32'd0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      send_a(3'b010);
      idle_a(8);
      check("post_abort_cnt", {24'b0, cnt_a}, 32'd1);

      repeat (255) send_a(3'($urandom));
      idle_a(8);
      check("wrap_cnt", {24'b0, cnt_a}, 32'd0);

      repeat (400) begin
         val_a = ($urandom_range(0, 2) != 0);
         din_a = 3'($urandom);
         tick();
      end
      idle_a(8);

      run_chk = 1'b0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
- Upstream feeder for the 3-bit serial sequence-detector FSM.
- Accepts a parallel word over a valid/ready handshake.
- Emits one frame per word: a one-cycle frame-clear pulse for the detector, then the word MSB-first one bit per clock, then a fixed idle gap.
- Produces exactly the clear / 3 bits / 1 idle clock pattern the detector expects, and counts completed frames.

Parameters:
- WIDTH, 3: bits per frame; legal range 1..16.
- GAP_CYCLES, 1: idle cycles after the last data bit; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  WIDTH  parallel word; sampled only on an accepted handshake.
- data_valid  input  1  producer has a word on data_in.
- data_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit to the detector's in.
- ser_valid  output  1  ser_out carries a data bit this cycle.
- frame_clr_n  output  1  active-low one-cycle clear to the detector, issued before each frame.
- frame_cnt  output  8  number of completed frames, modulo 256.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit/gap counters=0, frame_cnt=0.
- Outputs during reset: ser_out=0, ser_valid=0, frame_clr_n=1, data_ready=1.
- All outputs are decoded from registers only. No combinational path from data_valid or data_in to any output.
- Four states, 2-bit encoding: IDLE=0, CLEAR=1, SHIFT=2, GAP=3.
- IDLE:
  - data_ready=1; ser_valid=0; ser_out=0.
  - Accept occurs when data_valid=1 at a rising edge: latch data_in into the shift register, go to CLEAR.
- CLEAR:
  - Lasts exactly 1 cycle; frame_clr_n=0, data_ready=0, ser_valid=0.
  - Load bit counter with WIDTH-1, go to SHIFT.
- SHIFT:
  - ser_out = shift register MSB; ser_valid=1; data_ready=0.
  - Each edge: shift left (zero fill) and decrement the counter.
  - When the counter is 0 at an edge: frame_cnt increments (wraps 255->0). Next state is GAP if GAP_CYCLES>0, else IDLE.
  - Lasts exactly WIDTH cycles.
- GAP:
  - ser_valid=0, ser_out=0, data_ready=0.
  - Lasts exactly GAP_CYCLES cycles, then IDLE.
- Timing, with accept at edge k:
  - CLEAR during cycle k..k+1.
  - Bit i (MSB first) valid in cycle k+1+i+1 for i=0..WIDTH-1.
  - IDLE (ready again) after WIDTH+GAP_CYCLES+1 cycles following the accept.
- Frame period: WIDTH+GAP_CYCLES+2 cycles with a back-to-back producer. With defaults that is 6 cycles.
- Boundary conditions:
  - data_valid=1 while data_ready=0: ignored. The producer holds the word; no loss, no double accept.
  - data_in changing after accept: no effect on the frame in progress.
  - rst asserted mid-frame: frame aborted immediately and the word discarded. frame_clr_n returns to 1 and frame_cnt is cleared; the aborted frame is not counted.
  - WIDTH=1: SHIFT lasts one cycle.
  - GAP_CYCLES=0: transition SHIFT->IDLE directly.
  - frame_cnt wraps silently; there is no overflow flag.

Decomposition:
- Shared package/include (fsm_link_pkg) holds:
  - state encodings (IDLE/CLEAR/SHIFT/GAP, 2 bits);
  - default frame width 3 and default gap 1, also used by the detector bench;
  - counter width derived as clog2 of max(WIDTH, GAP_CYCLES+1).
- No sub-module. The FSM, shift register, one shared bit/gap down-counter and frame counter live in one module.

Test Plan:
- Reset: hold rst=0 with data_valid=1 -> data_ready=1, ser_valid=0, frame_clr_n=1, frame_cnt=0, no accept.
- Single word 3'b101 accepted at edge k -> frame_clr_n=0 for one cycle. Then ser_out=1,0,1 with ser_valid=1 for 3 cycles, then 1 gap cycle with ser_valid=0, then data_ready=1. frame_cnt=1.
- All 8 words 0..7 sent back-to-back with data_valid held high -> each frame spans 6 cycles, bits match MSB-first, frame_cnt=8. Bench with the detector attached: detector output matches the expected per-word result.
- Backpressure: data_in changes 3'b110->3'b011 during SHIFT while data_valid=1 -> the current frame still emits 1,1,0. The next frame emits 0,1,1, accepted only once data_ready=1.
- Reset mid-frame: rst=0 after the second bit of 3'b111 -> outputs return to reset values immediately; frame_cnt=0. A new word after release serializes cleanly.
- Wrap and parameters: 256 frames -> frame_cnt=0. Instance with WIDTH=1, GAP_CYCLES=0 -> 3-cycle frame period: CLEAR, one bit, then IDLE.
